output_collector: RTL and testbench
===================================

Name: output_collector

Overview:
- Downstream sink for the mesh output port: consumes result packets leaving the output router and assembles the full output spike map per timestep.
- Converts the packet stream into a row-addressed store. Once every row of every timestep has arrived, it streams the complete map out in order.
- This is the output memory stage that follows the NoC top level. The mesh-side port is bridged to valid/ready by a separate channel-to-handshake shim.

Parameters:
- WIDTH, 53, packet width in bits (13-bit header + payload).
- OUT_DIM, 21, output feature-map rows, and also spike bits per row.
- NUM_TS, 2, number of timesteps collected before a drain.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  packet offered by the mesh output port.
- in_ready  out  1  collector accepts a packet this cycle.
- in_data  in  WIDTH  packet.
- out_valid  out  1  drained row available.
- out_ready  in  1  consumer accepts the drained row.
- out_data  out  27  {ts[26], row[25:21], spikes[20:0]}.
- done  out  1  all OUT_DIM*NUM_TS rows received; high for the whole DRAIN.
- rows_rcvd  out  6  count of distinct rows stored this frame.
- err_cnt  out  ERR_W  saturating count of dropped packets.

Behaviour:
- Packet fields:
  - [1:0] dir
  - [4:2] x_hop
  - [7:5] y_hop
  - [11:8] source node
  - [12] type (1 = output-spike packet)
  - [13] ts
  - [18:14] row
  - [39:19] spikes
  - [WIDTH-1:40] ignored
- Reset (synchronous, sampled at a clk rising edge with rst=1):
  - state=COLLECT
  - in_ready=1, out_valid=0, out_data=0
  - done=0, rows_rcvd=0, err_cnt=0
  - all row-valid bits cleared
  - Reset mid-DRAIN or mid-COLLECT aborts everything; no partial output is emitted afterwards.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - Accept on in_valid & in_ready.
  - At the same edge, a good packet writes mem[ts][row] <= spikes, sets valid[ts][row], and increments rows_rcvd.
- Drop rules (the packet is consumed, never stalled):
  - type=0, or row >= OUT_DIM, or ts >= NUM_TS: drop, err_cnt+1.
  - valid[ts][row] already set: drop (the first copy wins), err_cnt+1.
  - err_cnt saturates at 2^ERR_W-1.
- COLLECT -> DRAIN:
  - Taken at the edge that accepts the row making rows_rcvd = OUT_DIM*NUM_TS.
  - in_ready is low from the next cycle onward.
  - done rises in the same cycle that out_valid first rises.
- State DRAIN:
  - in_ready=0, out_valid=1, done=1.
  - Drain pointer (ts, row) starts at (0,0).
  - out_data = {ts, row, mem[ts][row]}, driven combinationally from the registered pointer.
  - On out_valid & out_ready the pointer advances: row first, then ts.
  - out_data is stable while out_ready=0.
- DRAIN -> COLLECT:
  - Taken on the handshake of (NUM_TS-1, OUT_DIM-1).
  - Next cycle: done=0, rows_rcvd=0, all valid bits cleared, pointer reset, in_ready=1.
  - err_cnt persists across frames; only rst clears it.
- Latency:
  - Accept to stored: 1 edge.
  - Last row accepted to first out_valid: 1 cycle.
  - Full drain: OUT_DIM*NUM_TS handshakes minimum, one row per cycle when out_ready is held high.
- Simultaneous events:
  - The final-row accept and the state change happen on the same edge; no packet is accepted in the first DRAIN cycle.
  - Drop and count updates are mutually exclusive per packet.
- Memory contents are not cleared between frames; the valid bits alone gate overwrite.

Decomposition:
- Shared package (noc_pkg):
  - header field offsets/widths
  - PKT_TYPE_OUT
  - OUT_DIM, NUM_TS
  - out_data struct {ts, row, spikes}
  - collector state enum {COLLECT, DRAIN}
- One sub-module: spike_row_mem.
  - NUM_TS*OUT_DIM x OUT_DIM register array with valid bits.
  - Write port plus combinational read port.
  - Synchronous clear-valid input.

Test Plan:
- Ordered fill: send all 42 good packets with spikes = {ts,row} pattern, out_ready=1.
  - done rises 1 cycle after the 42nd accept.
  - Exactly 42 rows drain in order ts0 row0 .. ts1 row20 with matching spikes.
  - Then in_ready=1, rows_rcvd=0.
- Shuffled fill with back-pressure: random row order, out_ready toggled 50%.
  - Drain order is still ascending.
  - out_data holds while out_ready=0.
- Errors: inject type=0, row=21, and a duplicate of (1,5) with different spikes.
  - err_cnt=3, rows_rcvd unchanged by them.
  - Drained (1,5) carries the first copy.
- Reset mid-drain: assert rst after 10 handshakes.
  - out_valid=0, done=0, err_cnt=0 next cycle.
  - A subsequent full frame drains correctly.
- Saturation: send 300 bad packets, then complete a good frame.
  - err_cnt=255; the frame still drains normally.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg
// Shared definitions for the mesh output path.
//   - OUT_DIM / NUM_TS   : geometry of the output spike map (rows x timesteps)
//   - packet field layout: 13-bit routing header, then ts, row and spike payload
//   - out_data_t         : layout of one drained row {ts, row, spikes}
//   - collector_state_t  : collector phases (COLLECT, DRAIN)
//   - row_addr()         : flattens (ts, row) into a spike_row_mem address
package noc_pkg;

    localparam int OUT_DIM = 21;
    localparam int NUM_TS  = 2;

    localparam int TS_W    = 1;
    localparam int ROW_W   = 5;
    localparam int ROWS_W  = 6;
    localparam int DEPTH   = NUM_TS * OUT_DIM;
    localparam int ADDR_W  = $clog2(DEPTH);

    // Payload offsets above the 13-bit routing header
    localparam int HDR_W   = 13;
    localparam int TS_LSB  = 13;
    localparam int ROW_LSB = 14;
    localparam int SPK_LSB = 19;
    localparam int SPK_END = SPK_LSB + OUT_DIM;

    localparam logic PKT_TYPE_OUT = 1'b1;

    // Routing header as it sits in packet bits [12:0], dir in the LSBs
    typedef struct packed {
        logic       pkt_type;
        logic [3:0] src;
        logic [2:0] y_hop;
        logic [2:0] x_hop;
        logic [1:0] dir;
    } pkt_hdr_t;

    typedef struct packed {
        logic [TS_W-1:0]    ts;
        logic [ROW_W-1:0]   row;
        logic [OUT_DIM-1:0] spikes;
    } out_data_t;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } collector_state_t;

    // Row-major by timestep: ts0 rows occupy the bottom OUT_DIM entries
    function automatic logic [ADDR_W-1:0] row_addr(input logic [TS_W-1:0]  ts,
                                                   input logic [ROW_W-1:0] row);
        return ADDR_W'(int'(ts) * OUT_DIM + int'(row));
    endfunction

endpackage

// File: rtl/spike_row_mem.sv
// spike_row_mem
// Storage for one frame of output spike rows, NUM_TS*OUT_DIM entries of
// OUT_DIM bits, each with a valid bit.
//   clk        : clock
//   clr_valid  : synchronous clear of every valid bit (data is left as-is)
//   wr_en      : write wr_data at wr_addr and mark the entry valid
//   wr_addr    : write address (see row_addr)
//   wr_data    : spike row to store
//   chk_addr   : address whose valid bit is reported on chk_valid
//   chk_valid  : valid bit at chk_addr (combinational)
//   rd_addr    : read address
//   rd_data    : stored spike row at rd_addr (combinational)
module spike_row_mem
    import noc_pkg::*;
(
    input  logic               clk,
    input  logic               clr_valid,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [OUT_DIM-1:0] wr_data,
    input  logic [ADDR_W-1:0]  chk_addr,
    output logic               chk_valid,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [OUT_DIM-1:0] rd_data
);

    logic [OUT_DIM-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   valid_q;

    // Row data is never cleared; the valid bits alone decide what may be written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Valid bits: a clear wins over a write landing on the same edge
    always_ff @(posedge clk) begin
        if (clr_valid) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_addr] <= 1'b1;
        end
    end

    assign chk_valid = valid_q[chk_addr];
    assign rd_data   = mem[rd_addr];

endmodule

// File: rtl/output_collector.sv
// output_collector
// Sink for the mesh output port. Collects output-spike packets into a
// row-addressed store until every (ts, row) of the frame has arrived, then
// streams the whole map out in ascending (ts, row) order.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : packet offered
//   in_ready   : packet accepted this cycle (high throughout COLLECT)
//   in_data    : packet {ignored, spikes, row, ts, header}
//   out_valid  : drained row available (high throughout DRAIN)
//   out_ready  : consumer takes the drained row
//   out_data   : {ts, row, spikes}
//   done       : frame complete, high throughout DRAIN
//   rows_rcvd  : distinct rows stored in the current frame
//   err_cnt    : saturating count of dropped packets, cleared only by rst
module output_collector
    import noc_pkg::*;
#(
    parameter int WIDTH = 53,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [26:0]       out_data,
    output logic              done,
    output logic [5:0]        rows_rcvd,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int TOTAL_ROWS = OUT_DIM * NUM_TS;

    collector_state_t   state_q, state_d;
    logic [ROWS_W-1:0]  rows_q;
    logic [ERR_W-1:0]   err_q;
    logic [TS_W-1:0]    dr_ts_q;
    logic [ROW_W-1:0]   dr_row_q;

    pkt_hdr_t           hdr;
    logic [TS_W-1:0]    pkt_ts;
    logic [ROW_W-1:0]   pkt_row;
    logic [OUT_DIM-1:0] pkt_spikes;
    logic               unused_bits;

    logic               accept, hdr_ok, chk_valid, good, drop;
    logic               last_row, drain_hs, drain_last, drain_done, clr_valid;
    logic [OUT_DIM-1:0] rd_data;
    out_data_t          out_word;

    assign hdr         = pkt_hdr_t'(in_data[HDR_W-1:0]);
    assign pkt_ts      = in_data[TS_LSB +: TS_W];
    assign pkt_row     = in_data[ROW_LSB +: ROW_W];
    assign pkt_spikes  = in_data[SPK_LSB +: OUT_DIM];
    assign unused_bits = ^{hdr.src, hdr.y_hop, hdr.x_hop, hdr.dir, in_data[WIDTH-1:SPK_END]};

    // A packet is either stored or dropped, never both; the first copy of a row wins
    assign accept     = in_valid & in_ready;
    assign hdr_ok     = (hdr.pkt_type == PKT_TYPE_OUT) && (int'(pkt_row) < OUT_DIM)
                        && (int'(pkt_ts) < NUM_TS);
    assign good       = accept & hdr_ok & ~chk_valid;
    assign drop       = accept & ~(hdr_ok & ~chk_valid);
    assign last_row   = (rows_q == ROWS_W'(TOTAL_ROWS - 1));

    assign drain_hs   = (state_q == DRAIN) & out_ready;
    assign drain_last = (dr_ts_q == TS_W'(NUM_TS - 1)) && (dr_row_q == ROW_W'(OUT_DIM - 1));
    assign drain_done = drain_hs & drain_last;
    assign clr_valid  = rst | drain_done;

    spike_row_mem u_mem (
        .clk       (clk),
        .clr_valid (clr_valid),
        .wr_en     (good),
        .wr_addr   (row_addr(pkt_ts, pkt_row)),
        .wr_data   (pkt_spikes),
        .chk_addr  (row_addr(pkt_ts, pkt_row)),
        .chk_valid (chk_valid),
        .rd_addr   (row_addr(dr_ts_q, dr_row_q)),
        .rd_data   (rd_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the edge storing the final row switches to DRAIN, so no
    // packet can be taken in the first DRAIN cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (good && last_row) state_d = DRAIN;
            DRAIN:   if (drain_done)       state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Outputs decoded from state; out_data follows the registered drain pointer
    always_comb begin
        in_ready        = 1'b0;
        out_valid       = 1'b0;
        done            = 1'b0;
        out_word        = '0;
        case (state_q)
            COLLECT: in_ready = 1'b1;
            DRAIN: begin
                out_valid       = 1'b1;
                done            = 1'b1;
                out_word.ts     = dr_ts_q;
                out_word.row    = dr_row_q;
                out_word.spikes = rd_data;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign out_data  = out_word;
    assign rows_rcvd = rows_q;
    assign err_cnt   = err_q;

    // Row counter restarts once the last row of the frame has been drained
    always_ff @(posedge clk) begin
        if (rst || drain_done) begin
            rows_q <= '0;
        end else if (good) begin
            rows_q <= rows_q + ROWS_W'(1);
        end
    end

    // Error counter sticks at all-ones and survives frame boundaries
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (drop && (err_q != '1)) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    // Drain pointer walks rows first, then timesteps, and returns to (0,0)
    always_ff @(posedge clk) begin
        if (rst || drain_done) begin
            dr_ts_q  <= '0;
            dr_row_q <= '0;
        end else if (drain_hs) begin
            if (dr_row_q == ROW_W'(OUT_DIM - 1)) begin
                dr_row_q <= '0;
                dr_ts_q  <= dr_ts_q + TS_W'(1);
            end else begin
                dr_row_q <= dr_row_q + ROW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_output_collector.sv
// tb_output_collector
// Directed bench for output_collector: ordered fill, shuffled fill with
// consumer back-pressure and injected bad packets, reset during a drain, and
// error-counter saturation. Expected rows come from a small frame model.
module tb_output_collector;

    localparam int WIDTH   = 53;
    localparam int ERR_W   = 8;
    localparam int OUT_DIM = 21;
    localparam int NUM_TS  = 2;
    localparam int TOTAL   = OUT_DIM * NUM_TS;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [26:0]      out_data;
    logic             done;
    logic [5:0]       rows_rcvd;
    logic [ERR_W-1:0] err_cnt;

    int total = 0;
    int bad   = 0;

    logic [20:0] exp_mem   [NUM_TS][OUT_DIM];
    bit          exp_valid [NUM_TS][OUT_DIM];
    int          exp_rows;
    int          exp_err;

    always #5 clk = ~clk;

    output_collector #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done      (done),
        .rows_rcvd (rows_rcvd),
        .err_cnt   (err_cnt)
    );

    // One comparison: count it, report it when it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Header junk and ignored upper bits are filled so the DUT must not look at them
    function automatic logic [WIDTH-1:0] make_pkt(input logic typ, input logic ts,
                                                  input logic [4:0] row, input logic [20:0] spk);
        logic [WIDTH-1:0] p;
        p          = '0;
        p[52:40]   = 13'h1abc ^ {8'h00, row};
        p[1:0]     = 2'b10;
        p[4:2]     = 3'd3;
        p[7:5]     = 3'd5;
        p[11:8]    = 4'hc;
        p[12]      = typ;
        p[13]      = ts;
        p[18:14]   = row;
        p[39:19]   = spk;
        return p;
    endfunction

    function automatic logic [20:0] pat(input logic [14:0] seed, input int ts, input int row);
        return {seed, 1'(ts), 5'(row)};
    endfunction

    task automatic clearFrameModel();
        for (int t = 0; t < NUM_TS; t++)
            for (int r = 0; r < OUT_DIM; r++)
                exp_valid[t][r] = 1'b0;
        exp_rows = 0;
    endtask

    // Offer one packet for one cycle and update the frame model
    task automatic applyStimulus(input logic [WIDTH-1:0] pkt);
        logic       ts;
        logic [4:0] row;
        ts  = pkt[13];
        row = pkt[18:14];
        if (pkt[12] && (row < 5'd21) && !exp_valid[ts][row]) begin
            exp_mem[ts][row]   = pkt[39:19];
            exp_valid[ts][row] = 1'b1;
            exp_rows++;
        end else if (exp_err < 255) begin
            exp_err++;
        end
        in_valid = 1'b1;
        in_data  = pkt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Ordered fill; checks the frame is not yet done just before the last row
    task automatic sendOrdered(input logic [14:0] seed);
        for (int i = 0; i < TOTAL; i++) begin
            if (i == TOTAL - 1) begin
                checkOutput("rows_before_last", 32'(rows_rcvd), 32'(TOTAL - 1));
                checkOutput("done_before_last", 32'(done), 32'd0);
            end
            applyStimulus(make_pkt(1'b1, 1'(i / OUT_DIM), 5'(i % OUT_DIM),
                                   pat(seed, i / OUT_DIM, i % OUT_DIM)));
        end
    endtask

    // Drain 'count' rows from (0,0); with bp set, out_ready drops for up to 3 cycles per row
    task automatic drainFrame(input bit bp, input int count);
        logic [26:0] exp_word;
        for (int idx = 0; idx < count; idx++) begin
            int t;
            int r;
            int waits;
            t        = idx / OUT_DIM;
            r        = idx % OUT_DIM;
            waits    = 0;
            exp_word = {1'(t), 5'(r), exp_mem[t][r]};
            checkOutput("drain_word", 32'({out_valid, done, out_data}), 32'({2'b11, exp_word}));
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!out_ready) begin
                @(posedge clk);
                #1;
                checkOutput("hold_word", 32'({out_valid, done, out_data}), 32'({2'b11, exp_word}));
                waits++;
                out_ready = (waits >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic checkBackToCollect(input string tag);
        checkOutput({tag, "_in_ready"},  32'(in_ready),  32'd1);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_done"},      32'(done),      32'd0);
        checkOutput({tag, "_rows"},      32'(rows_rcvd), 32'd0);
        checkOutput({tag, "_err"},       32'(err_cnt),   32'(exp_err));
        clearFrameModel();
    endtask

    task automatic checkDrainEntry(input string tag);
        checkOutput({tag, "_done"},     32'(done),     32'd1);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ord [TOTAL];
        int tmp;
        int j;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        exp_err   = 0;
        clearFrameModel();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data",  32'(out_data),  32'd0);
        checkOutput("rst_done",      32'(done),      32'd0);
        checkOutput("rst_rows",      32'(rows_rcvd), 32'd0);
        checkOutput("rst_err",       32'(err_cnt),   32'd0);

        $display("[TB] ordered fill, full-rate drain, packet offered during drain");
        sendOrdered(15'h1234);
        checkDrainEntry("a_entry");
        in_valid = 1'b1;
        in_data  = make_pkt(1'b0, 1'b0, 5'd3, 21'h0);
        drainFrame(1'b0, TOTAL);
        in_valid = 1'b0;
        in_data  = '0;
        checkBackToCollect("a_exit");

        $display("[TB] shuffled fill with bad packets and back-pressure");
        for (int i = 0; i < TOTAL; i++) ord[i] = i;
        for (int i = TOTAL - 1; i > 0; i--) begin
            j      = int'($urandom_range(0, i));
            tmp    = ord[i];
            ord[i] = ord[j];
            ord[j] = tmp;
        end
        if (ord[TOTAL - 1] == OUT_DIM + 5) begin
            tmp            = ord[0];
            ord[0]         = ord[TOTAL - 1];
            ord[TOTAL - 1] = tmp;
        end
        for (int i = 0; i < TOTAL - 1; i++)
            applyStimulus(make_pkt(1'b1, 1'(ord[i] / OUT_DIM), 5'(ord[i] % OUT_DIM),
                                   pat(15'h0b5e, ord[i] / OUT_DIM, ord[i] % OUT_DIM)));
        applyStimulus(make_pkt(1'b0, 1'(ord[TOTAL - 1] / OUT_DIM), 5'(ord[TOTAL - 1] % OUT_DIM),
                               21'h1fffff));
        applyStimulus(make_pkt(1'b1, 1'b0, 5'd21, 21'h0aaaaa));
        applyStimulus(make_pkt(1'b1, 1'b1, 5'd5, ~pat(15'h0b5e, 1, 5)));
        checkOutput("b_err_after_inject",  32'(err_cnt),   32'd3);
        checkOutput("b_rows_after_inject", 32'(rows_rcvd), 32'(TOTAL - 1));
        checkOutput("b_done_after_inject", 32'(done),      32'd0);
        applyStimulus(make_pkt(1'b1, 1'(ord[TOTAL - 1] / OUT_DIM), 5'(ord[TOTAL - 1] % OUT_DIM),
                               pat(15'h0b5e, ord[TOTAL - 1] / OUT_DIM, ord[TOTAL - 1] % OUT_DIM)));
        checkDrainEntry("b_entry");
        drainFrame(1'b1, TOTAL);
        checkBackToCollect("b_exit");

        $display("[TB] reset during drain");
        sendOrdered(15'h2c3d);
        checkDrainEntry("c_entry");
        drainFrame(1'b0, 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_err = 0;
        checkOutput("c_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("c_rst_done",      32'(done),      32'd0);
        checkOutput("c_rst_err",       32'(err_cnt),   32'd0);
        checkOutput("c_rst_rows",      32'(rows_rcvd), 32'd0);
        checkOutput("c_rst_in_ready",  32'(in_ready),  32'd1);
        clearFrameModel();
        sendOrdered(15'h4e5f);
        checkDrainEntry("d_entry");
        drainFrame(1'b0, TOTAL);
        checkBackToCollect("d_exit");

        $display("[TB] error counter saturation");
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0)
                applyStimulus(make_pkt(1'b0, 1'(i % 2), 5'(i % OUT_DIM), 21'(i)));
            else
                applyStimulus(make_pkt(1'b1, 1'(i % 2), 5'd25, 21'(i)));
        end
        checkOutput("e_err_saturated", 32'(err_cnt),   32'd255);
        checkOutput("e_rows_unchanged", 32'(rows_rcvd), 32'd0);
        sendOrdered(15'h7a61);
        checkDrainEntry("e_entry");
        drainFrame(1'b1, TOTAL);
        checkBackToCollect("e_exit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
